// File: rtl/matrix_scan_if.sv
// Signal bundle between a pixel-map source and the 7x5 matrix scan driver.
// The master supplies maps and enable; the slave drives the matrix.
interface matrix_scan_if;
    logic        en;
    logic [34:0] map_in;
    logic        load;
    logic [6:0]  row;
    logic [4:0]  col;
    logic [2:0]  row_idx;
    logic        frame_start;
    logic        load_ack;

    modport master (
        output en, map_in, load,
        input  row, col, row_idx, frame_start, load_ack
    );

    modport slave (
        input  en, map_in, load,
        output row, col, row_idx, frame_start, load_ack
    );
endinterface

// File: rtl/matrix_scan.sv
// Row-multiplexed 7x5 LED matrix scanner.
// Maps are double-buffered and swapped only at frame boundaries.
module matrix_scan #(
    parameter int ROW_CYCLES   = 4,
    parameter int BLANK_CYCLES = 1
) (
    input logic         clk,
    input logic         reset,
    matrix_scan_if.slave bus
);
    localparam int MAXC = (ROW_CYCLES > BLANK_CYCLES) ?
                          ROW_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ROW_LD = CW'(ROW_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LD =
        CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LIT, BLANK} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  row_idx_q, row_idx_d;
    logic [6:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic        frame_start_q, frame_start_d;
    logic        load_ack_q, load_ack_d;
    logic [34:0] buffer_q, buffer_d;
    logic [34:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;

    logic        enter_lit;
    logic        boundary;
    logic [2:0]  lit_idx;
    logic [2:0]  nxt_idx;
    logic [5:0]  base;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_idx_d     = row_idx_q;
        row_d         = row_q;
        col_d         = col_q;
        frame_start_d = 1'b0;
        load_ack_d    = 1'b0;
        buffer_d      = buffer_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        enter_lit     = 1'b0;
        boundary      = 1'b0;
        lit_idx       = 3'd0;
        base          = 6'd0;
        nxt_idx       = (row_idx_q == 3'd6) ? 3'd0 : row_idx_q + 3'd1;

        if (bus.load) begin
            shadow_d  = bus.map_in;
            pending_d = 1'b1;
        end

        if (!bus.en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            row_idx_d = 3'd0;
            row_d     = 7'd0;
            col_d     = 5'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    enter_lit = 1'b1;
                    boundary  = 1'b1;
                end
                LIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (BLANK_CYCLES > 0) begin
                        state_d = BLANK;
                        cnt_d   = BLK_LD;
                        row_d   = 7'd0;
                        col_d   = 5'd0;
                    end else begin
                        enter_lit = 1'b1;
                        lit_idx   = nxt_idx;
                        boundary  = (nxt_idx == 3'd0);
                    end
                end
                BLANK: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        enter_lit = 1'b1;
                        lit_idx   = nxt_idx;
                        boundary  = (nxt_idx == 3'd0);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A load on the boundary edge itself beats the older shadow copy.
        if (boundary) begin
            if (bus.load) begin
                buffer_d = bus.map_in;
            end else if (pending_q) begin
                buffer_d = shadow_q;
            end
            if (bus.load || pending_q) begin
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end
        end

        if (enter_lit) begin
            state_d   = LIT;
            cnt_d     = ROW_LD;
            row_idx_d = lit_idx;
            row_d     = 7'd1 << lit_idx;
            base      = {3'd0, lit_idx} * 6'd5;
            col_d     = buffer_d[base +: 5];
        end

        frame_start_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            row_idx_q     <= 3'd0;
            row_q         <= 7'd0;
            col_q         <= 5'd0;
            frame_start_q <= 1'b0;
            load_ack_q    <= 1'b0;
            buffer_q      <= 35'd0;
            shadow_q      <= 35'd0;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_idx_q     <= row_idx_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
            load_ack_q    <= load_ack_d;
            buffer_q      <= buffer_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
        end
    end

    assign bus.row         = row_q;
    assign bus.col         = col_q;
    assign bus.row_idx     = row_idx_q;
    assign bus.frame_start = frame_start_q;
    assign bus.load_ack    = load_ack_q;
endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: default timing plus a 1/0 variant.
module tb_matrix_scan;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    localparam logic [34:0] ONES = 35'h7_FFFF_FFFF;
    localparam logic [34:0] PIX  = 35'h0_0002_0000;
    localparam logic [34:0] ZERO = 35'h0;

    matrix_scan_if ifa ();
    matrix_scan_if ifb ();

    matrix_scan u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    matrix_scan #(.ROW_CYCLES(1), .BLANK_CYCLES(0)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs,
                       input logic [16:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %05h expected %05h", tag, obs, exp);
    endtask

    function automatic logic [16:0] obs_a();
        return {ifa.row, ifa.col, ifa.row_idx,
                ifa.frame_start, ifa.load_ack};
    endfunction

    function automatic logic [16:0] obs_b();
        return {ifb.row, ifb.col, ifb.row_idx,
                ifb.frame_start, ifb.load_ack};
    endfunction

    // Starts on the negedge of the first lit cycle of row 0.
    task automatic frame_check(input string nm, input logic [34:0] m,
                               input logic la0, input int n,
                               input int l1_t, input logic [34:0] l1_v,
                               input int l2_t, input logic [34:0] l2_v);
        for (int t = 0; t < n; t++) begin
            int r;
            int ph;
            logic [6:0] er;
            logic [4:0] ec;
            r  = t / 5;
            ph = t % 5;
            er = (ph < 4) ? (7'd1 << r) : 7'd0;
            ec = (ph < 4) ? m[5*r +: 5] : 5'd0;
            chk($sformatf("%s_t%0d", nm, t), obs_a(),
                {er, ec, 3'(r), t == 0, la0 && (t == 0)});
            if (t == l1_t) begin
                ifa.load = 1'b1;
                ifa.map_in = l1_v;
            end else if (t == l2_t) begin
                ifa.load = 1'b1;
                ifa.map_in = l2_v;
            end else begin
                ifa.load = 1'b0;
            end
            @(negedge clk);
        end
        ifa.load = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        ifa.en = 1'b0; ifa.load = 1'b0; ifa.map_in = ZERO;
        ifb.en = 1'b0; ifb.load = 1'b0; ifb.map_in = ZERO;
        #1;
        chk("reset_init", obs_a(), 17'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle0", obs_a(), 17'd0);
        @(negedge clk);
        chk("idle1", obs_a(), 17'd0);

        ifa.load = 1'b1;
        ifa.map_in = PIX;
        @(negedge clk);
        ifa.load = 1'b0;
        ifa.en = 1'b1;
        @(negedge clk);
        frame_check("pix1", PIX, 1'b1, 35, -1, ZERO, -1, ZERO);
        frame_check("pix2", PIX, 1'b0, 35, 0, ONES, -1, ZERO);
        frame_check("ones", ONES, 1'b1, 35, 15, ZERO, -1, ZERO);
        frame_check("zero", ZERO, 1'b1, 35, 5, ONES, 20, PIX);
        frame_check("pix3", PIX, 1'b1, 21, -1, ZERO, -1, ZERO);

        ifa.en = 1'b0;
        ifa.load = 1'b1;
        ifa.map_in = ONES;
        @(negedge clk);
        chk("en_drop", obs_a(), 17'd0);
        ifa.load = 1'b0;
        @(negedge clk);
        chk("en_low", obs_a(), 17'd0);
        ifa.en = 1'b1;
        @(negedge clk);
        frame_check("restart", ONES, 1'b1, 7, 3, ZERO, -1, ZERO);
        chk("pre_reset", obs_a(), {7'd2, 5'h1f, 3'd1, 1'b0, 1'b0});

        reset = 1'b1;
        ifa.en = 1'b0;
        #1;
        chk("reset_mid", obs_a(), 17'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_held", obs_a(), 17'd0);
        @(negedge clk);
        chk("post_reset", obs_a(), 17'd0);
        ifa.en = 1'b1;
        @(negedge clk);
        frame_check("cleared", ZERO, 1'b0, 35, -1, ZERO, -1, ZERO);
        ifa.en = 1'b0;

        ifb.load = 1'b1;
        ifb.map_in = ONES;
        ifb.en = 1'b1;
        @(negedge clk);
        ifb.load = 1'b0;
        for (int t = 0; t < 15; t++) begin
            chk($sformatf("fast_t%0d", t), obs_b(),
                {7'd1 << (t % 7), 5'h1f, 3'(t % 7),
                 (t % 7) == 0, t == 0});
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
